// File: rtl/inst_fetch_queue_pkg.sv
// Shared defaults and types for the fetch-to-decode instruction queue.
package inst_fetch_queue_pkg;

    localparam int IQ_DEPTH_DEF   = 4;
    localparam int IQ_PC_W_DEF    = 32;
    localparam int IQ_INST_W_DEF  = 32;
    localparam int IQ_ECODE_W_DEF = 6;

    // ADEF: instruction fetch address error, the usual fetch-side exception code
    localparam logic [IQ_ECODE_W_DEF-1:0] ECODE_ADEF = 6'h08;

    // Queue operation for one cycle, encoded as {push, pop}
    typedef enum logic [1:0] {
        IQ_OP_IDLE = 2'b00,
        IQ_OP_POP  = 2'b01,
        IQ_OP_PUSH = 2'b10,
        IQ_OP_BOTH = 2'b11
    } iq_op_e;

    function automatic int iq_entry_width(input int pc_w, input int inst_w, input int ecode_w);
        return pc_w + inst_w + 1 + ecode_w;
    endfunction

endpackage

// File: rtl/inst_fetch_queue_ram.sv
// Queue storage: one synchronous write port, one asynchronous read port, no reset.
module inst_fetch_queue_ram #(
    parameter int WIDTH = 71,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head entry must be visible the cycle after it is written, so the read is combinational.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction queue between fetch and decode: FIFO of {pc, inst, excp, ecode} with flush.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int DEPTH   = IQ_DEPTH_DEF,
    parameter int PC_W    = IQ_PC_W_DEF,
    parameter int INST_W  = IQ_INST_W_DEF,
    parameter int ECODE_W = IQ_ECODE_W_DEF,
    parameter int PTR_W   = $clog2(DEPTH),
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    input  logic               fs_valid_i,
    output logic               fs_allowin_o,
    input  logic [PC_W-1:0]    fs_pc_i,
    input  logic [INST_W-1:0]  fs_inst_i,
    input  logic               fs_excp_i,
    input  logic [ECODE_W-1:0] fs_ecode_i,
    input  logic               ds_allowin_i,
    output logic               ds_valid_o,
    output logic [PC_W-1:0]    ds_pc_o,
    output logic [INST_W-1:0]  ds_inst_o,
    output logic               ds_excp_o,
    output logic [ECODE_W-1:0] ds_ecode_o,
    output logic [CNT_W-1:0]   count_o
);

    localparam int ENTRY_W = iq_entry_width(PC_W, INST_W, ECODE_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             push;
    logic             pop;
    logic             ram_we;
    iq_op_e           op;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // Handshakes look only at the registered count, never at the partner's input.
    assign fs_allowin_o = (count_q != CNT_FULL);
    assign ds_valid_o   = (count_q != '0);
    assign count_o      = count_q;

    assign push = fs_valid_i & fs_allowin_o;
    assign pop  = ds_valid_o & ds_allowin_i;
    assign op   = iq_op_e'({push, pop});

    assign ram_we   = push & ~flush_i;
    assign wr_entry = {fs_pc_i, fs_inst_i, fs_excp_i, fs_ecode_i};

    inst_fetch_queue_ram #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH),
        .AW    (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_entry)
    );

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            case (op)
                IQ_OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    count_d  = count_q + 1'b1;
                end
                IQ_OP_POP: begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    count_d  = count_q - 1'b1;
                end
                IQ_OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Stale storage must not leak to decode when the queue is empty.
    always_comb begin
        ds_pc_o    = '0;
        ds_inst_o  = '0;
        ds_excp_o  = 1'b0;
        ds_ecode_o = '0;
        if (ds_valid_o) begin
            {ds_pc_o, ds_inst_o, ds_excp_o, ds_ecode_o} = rd_entry;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed checks of the instruction fetch queue with hand-computed expectations.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        fs_valid_i;
    logic        fs_allowin_o;
    logic [31:0] fs_pc_i;
    logic [31:0] fs_inst_i;
    logic        fs_excp_i;
    logic [5:0]  fs_ecode_i;
    logic        ds_allowin_i;
    logic        ds_valid_o;
    logic [31:0] ds_pc_o;
    logic [31:0] ds_inst_o;
    logic        ds_excp_o;
    logic [5:0]  ds_ecode_o;
    logic [2:0]  count_o;

    int n_checks = 0;
    int n_errors = 0;

    inst_fetch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .fs_valid_i   (fs_valid_i),
        .fs_allowin_o (fs_allowin_o),
        .fs_pc_i      (fs_pc_i),
        .fs_inst_i    (fs_inst_i),
        .fs_excp_i    (fs_excp_i),
        .fs_ecode_i   (fs_ecode_i),
        .ds_allowin_i (ds_allowin_i),
        .ds_valid_o   (ds_valid_o),
        .ds_pc_o      (ds_pc_o),
        .ds_inst_o    (ds_inst_o),
        .ds_excp_o    (ds_excp_o),
        .ds_ecode_o   (ds_ecode_o),
        .count_o      (count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance one clock; inputs and observations happen 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'hdead_0000;
    endfunction

    task automatic drive(input logic v, input logic [31:0] pc, input logic a);
        fs_valid_i   = v;
        fs_pc_i      = pc;
        fs_inst_i    = inst_of(pc);
        ds_allowin_i = a;
    endtask

    task automatic check_head(input string tag, input logic [2:0] cnt, input logic [31:0] pc);
        check({tag, ".count"}, 64'(count_o), 64'(cnt));
        check({tag, ".valid"}, 64'(ds_valid_o), 64'(cnt != 3'd0));
        check({tag, ".pc"}, 64'(ds_pc_o), 64'(pc));
        check({tag, ".inst"}, 64'(ds_inst_o), (cnt != 3'd0) ? 64'(inst_of(pc)) : 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush_i = 1'b0;
        fs_excp_i = 1'b0; fs_ecode_i = 6'h0;
        drive(1'b0, 32'h0, 1'b0);
        step(); step();
        rst = 1'b0;
        step();

        // Reset/idle state
        check("rst.valid", 64'(ds_valid_o), 64'd0);
        check("rst.allowin", 64'(fs_allowin_o), 64'd1);
        check("rst.count", 64'(count_o), 64'd0);
        check("rst.inst", 64'(ds_inst_o), 64'd0);

        // Fill to full with decode stalled
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h1c00_0000 + 32'(4 * i), 1'b0);
            step();
            check_head($sformatf("fill%0d", i), 3'(i + 1), 32'h1c00_0000);
        end
        check("full.allowin", 64'(fs_allowin_o), 64'd0);
        drive(1'b1, 32'h1c00_0010, 1'b0);
        step();
        check_head("full.blocked", 3'd4, 32'h1c00_0000);

        // Drain from full: first cycle pop only, second push+pop, then pops only
        drive(1'b1, 32'h1c00_0010, 1'b1);
        step();
        check_head("drain0", 3'd3, 32'h1c00_0004);
        check("drain0.allowin", 64'(fs_allowin_o), 64'd1);
        step();
        check_head("drain1", 3'd3, 32'h1c00_0008);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_head("drain2", 3'd2, 32'h1c00_000c);
        step();
        check_head("drain3", 3'd1, 32'h1c00_0010);
        step();
        check_head("drain4", 3'd0, 32'h0);

        // Steady push+pop across pointer wrap
        drive(1'b1, 32'h0000_0100, 1'b0);
        step();
        check_head("steady.pre", 3'd1, 32'h0000_0100);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'h0000_0104 + 32'(4 * k), 1'b1);
            step();
            check_head($sformatf("steady%0d", k), 3'd1, 32'h0000_0104 + 32'(4 * k));
        end
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_head("steady.end", 3'd0, 32'h0);

        // Flush with count=3 while push and pop are both requested
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_0200 + 32'(4 * i), 1'b0);
            step();
        end
        check_head("preflush", 3'd3, 32'h0000_0200);
        flush_i = 1'b1;
        drive(1'b1, 32'h0000_02ff, 1'b1);
        step();
        flush_i = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check_head("flush", 3'd0, 32'h0);
        check("flush.allowin", 64'(fs_allowin_o), 64'd1);
        drive(1'b1, 32'h0000_0300, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check_head("postflush", 3'd1, 32'h0000_0300);
        drive(1'b0, 32'h0, 1'b1);
        step();

        // Exception entry travels like a normal one
        fs_excp_i = 1'b1; fs_ecode_i = 6'h08;
        drive(1'b1, 32'h0000_0400, 1'b0);
        step();
        fs_excp_i = 1'b0; fs_ecode_i = 6'h00;
        drive(1'b1, 32'h0000_0404, 1'b0);
        step();
        check_head("excp", 3'd2, 32'h0000_0400);
        check("excp.flag", 64'(ds_excp_o), 64'd1);
        check("excp.ecode", 64'(ds_ecode_o), 64'h08);
        drive(1'b0, 32'h0, 1'b1);
        step();
        check_head("after_excp", 3'd1, 32'h0000_0404);
        check("after_excp.flag", 64'(ds_excp_o), 64'd0);
        check("after_excp.ecode", 64'(ds_ecode_o), 64'h00);

        // Reset mid-stream behaves like a flush
        drive(1'b1, 32'h0000_0500, 1'b0);
        step();
        check_head("prerst", 3'd2, 32'h0000_0404);
        rst = 1'b1;
        drive(1'b1, 32'h0000_05ff, 1'b1);
        step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        check_head("midrst", 3'd0, 32'h0);
        check("midrst.allowin", 64'(fs_allowin_o), 64'd1);
        drive(1'b1, 32'h0000_0600, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        check_head("postrst", 3'd1, 32'h0000_0600);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
